multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Control sequencer that runs the existing single-cycle datapath elements as a multicycle MIPS processor with one shared memory. It replaces the combinational opcode decoder and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It drives the mux selects, register write enable, memory strobes and PC enables. It waits on a memory-ready handshake and flags illegal opcodes.

Parameters:
FETCH_WAIT_MAX, 15, maximum cycles spent waiting for mem_ready in any memory state before mem_timeout is raised.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
run  input  1  allows a new fetch to start; sampled only in FETCH entry
OP  input  6  instruction-register bits [31:26]
Funct  input  6  instruction-register bits [5:0]
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completed the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCondEQ  output  1  load PC if Zero
PCWriteCondNE  output  1  load PC if !Zero
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  2  0 = ALUOut, 1 = MDR, 2 = PC (for jal)
RegDst  output  2  0 = rt, 1 = rd, 2 = $31
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  0 = B, 1 = const 4, 2 = signext, 3 = signext<<2
ALUOp  output  3  ALU control class (package constants)
PCSource  output  2  0 = ALU, 1 = ALUOut, 2 = jump target, 3 = A (jr)
state_out  output  4  current state encoding, for debug
illegal_op  output  1  sticky; set on an unknown opcode
mem_timeout  output  1  sticky; set when a wait exceeds FETCH_WAIT_MAX

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset state: state = FETCH. Wait counter = 0. illegal_op = 0. mem_timeout = 0. All control outputs are forced to 0 while reset is high. The first fetch begins on the first clk edge after reset falls, provided run = 1.
- Output style: outputs are Moore-decoded from the state. The only exceptions are IRWrite, PCWrite (in FETCH) and the advance out of memory states, which are additionally gated by mem_ready.
- IDLE: all outputs 0. Go to FETCH when run = 1.
- FETCH: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 1, ALUOp = ADD, PCSource = 0.
  - If mem_ready = 1: IRWrite = 1 and PCWrite = 1 in the same cycle, then go to DECODE.
  - If mem_ready = 0: stay in FETCH and increment the wait counter.
  - If run = 0 on FETCH entry: go to IDLE instead.
- DECODE: ALUSrcA = 0, ALUSrcB = 3, ALUOp = ADD (computes the branch target). Dispatch on OP:
  - lw/sw -> MEMADDR
  - R-type with Funct = jr -> JR
  - other R-type -> EXEC_R
  - addi/ori/andi/slti/lui -> EXEC_I
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - any other opcode: set illegal_op, go to FETCH.
- MEMADDR: ALUSrcA = 1, ALUSrcB = 2, ALUOp = ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1, MemRead = 1. Advance to WB_MEM on mem_ready.
- MEMWR: IorD = 1, MemWrite = 1. Advance to FETCH on mem_ready.
- WB_MEM: RegDst = 0, MemtoReg = 1, RegWrite = 1. Go to FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 0, ALUOp = RTYPE. Go to WB_R.
- WB_R: RegDst = 1, MemtoReg = 0, RegWrite = 1. Go to FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 2, ALUOp = the class for the opcode (ADD/OR/AND/SLT/LUI). Go to WB_I.
- WB_I: RegDst = 0, MemtoReg = 0, RegWrite = 1. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 0, ALUOp = SUB, PCSource = 1. PCWriteCondEQ = 1 for beq, PCWriteCondNE = 1 for bne. Go to FETCH.
- JUMP: PCSource = 2, PCWrite = 1. Go to FETCH.
- JAL: PCSource = 2, PCWrite = 1, RegDst = 2, MemtoReg = 2, RegWrite = 1. PC still holds PC+4 during this cycle, so $31 receives PC+4. Go to FETCH.
- JR: PCSource = 3, PCWrite = 1. Go to FETCH.
- Latency with mem_ready tied to 1:
  - R-type / I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne/j/jal/jr: 3 cycles
- Wait counter: cleared on every state change. When it reaches FETCH_WAIT_MAX, set mem_timeout (sticky), abort the access and go to FETCH with no register or PC write.
- Strobe ordering: MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- Reset mid-instruction: all outputs drop in the same cycle reset rises. A partial instruction never commits. The sticky flags are cleared.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum (4-bit)
  - opcode constants: R=6'h00, j=02, jal=03, beq=04, bne=05, addi=08, slti=0A, andi=0C, ori=0D, lui=0F, lw=23, sw=2B
  - FUNCT_JR = 6'h08
  - ALUOp class constants: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5, RTYPE=7
- One sub-module, mc_output_decoder: a combinational state+OP -> control-vector lookup. The main module keeps the state register, wait counter and sticky flags.

Test Plan:
1. Reset pulse mid-WB_R -> all outputs 0 immediately; after release, state_out = FETCH and MemRead = 1 with IorD = 0.
2. add (OP = 0, Funct = 0x20), mem_ready = 1 -> FETCH, DECODE, EXEC_R, WB_R; RegWrite = 1 and RegDst = 1 only in cycle 4; IRWrite pulses once.
3. lw with mem_ready low for 3 cycles in MEMRD -> stays in MEMRD for 4 cycles, then WB_MEM with MemtoReg = 1; total latency 8 cycles.
4. beq with Zero = 1, then bne with Zero = 1 -> PCWriteCondEQ = 1 in BRANCH, then PCWriteCondNE = 1 in BRANCH; PCSource = 1 both times; no RegWrite.
5. jal then jr (Funct = 0x08) -> JAL: RegDst = 2, MemtoReg = 2, PCSource = 2, PCWrite = 1; JR: PCSource = 3, PCWrite = 1; each 3 cycles.
6. OP = 0x3F -> illegal_op = 1 after DECODE, returns to FETCH; mem_ready held 0 for 15 cycles -> mem_timeout = 1, no writes.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared state, opcode, ALU-class and control-vector definitions for the multicycle controller
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_IDLE,
    S_DECODE,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWR,
    S_WB_MEM,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_LUI   = 3'd5;
  localparam logic [2:0] ALU_RTYPE = 3'd7;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic [2:0] alu_class(input logic [5:0] op);
    return op == OP_ORI  ? ALU_OR  :
           op == OP_ANDI ? ALU_AND :
           op == OP_SLTI ? ALU_SLT :
           op == OP_LUI  ? ALU_LUI : ALU_ADD;
  endfunction

  // Unknown opcodes map to S_FETCH, which doubles as the illegal-opcode marker.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_LW, OP_SW:                             return S_MEMADDR;
      OP_R:                                     return funct == FUNCT_JR ? S_JR : S_EXEC_R;
      OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LUI: return S_EXEC_I;
      OP_BEQ, OP_BNE:                           return S_BRANCH;
      OP_J:                                     return S_JUMP;
      OP_JAL:                                   return S_JAL;
      default:                                  return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// mc_output_decoder: Moore control-vector lookup from state and opcode
module mc_output_decoder
  import mips_mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       ready,
  output ctrl_t      ctrl
);

  // ready only qualifies the instruction/PC load of a completing fetch
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'd1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'd3;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWR: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.mem_to_reg = 2'd1;
        ctrl.reg_write  = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        ctrl.reg_dst   = 2'd1;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = alu_class(op);
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_op      = ALU_SUB;
        ctrl.pc_source   = 2'd1;
        ctrl.pc_write_eq = op == OP_BEQ;
        ctrl.pc_write_ne = op == OP_BNE;
      end
      S_JUMP: begin
        ctrl.pc_source = 2'd2;
        ctrl.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_source  = 2'd2;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_dst    = 2'd2;
        ctrl.mem_to_reg = 2'd2;
        ctrl.reg_write  = 1'b1;
      end
      S_JR: begin
        ctrl.pc_source = 2'd3;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS sequencer with memory-ready waits, timeout and illegal-opcode flags
module multicycle_control_fsm
  import mips_mc_pkg::*;
#(
  parameter int FETCH_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state_out,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int CW = $clog2(FETCH_WAIT_MAX + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          fetch_ok, fetch_go, stall, expire, bad_op, unused_zero;
  ctrl_t         dec, ctrl;

  // The branch decision on Zero is made in the datapath from the PCWriteCond strobes.
  assign unused_zero = Zero;
  // run is only honoured on the first cycle in FETCH; once a wait has started the fetch is committed.
  assign fetch_ok = state != S_FETCH || cnt != '0 || run;
  assign fetch_go = mem_ready && fetch_ok;
  assign stall    = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && fetch_ok && !mem_ready;
  assign expire   = stall && cnt == CW'(FETCH_WAIT_MAX - 1);
  assign bad_op   = state == S_DECODE && dispatch(OP, Funct) == S_FETCH;

  mc_output_decoder u_dec (
    .state (state),
    .op    (OP),
    .ready (fetch_go),
    .ctrl  (dec)
  );

  // next-state selection; an expired wait abandons the access and refetches
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = run ? S_FETCH : S_IDLE;
      S_FETCH:   nxt = !fetch_ok ? S_IDLE : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  nxt = dispatch(OP, Funct);
      S_MEMADDR: nxt = OP == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = mem_ready ? S_WB_MEM : S_MEMRD;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R:  nxt = S_WB_R;
      S_EXEC_I:  nxt = S_WB_I;
      default:   nxt = S_FETCH;
    endcase
    if (expire) nxt = S_FETCH;
  end

  // state register, wait counter and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      cnt         <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= stall && !expire ? cnt + 1'b1 : '0;
      illegal_op  <= illegal_op | bad_op;
      mem_timeout <= mem_timeout | expire;
    end
  end

  assign ctrl          = reset ? '0 : dec;
  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCondEQ = ctrl.pc_write_eq;
  assign PCWriteCondNE = ctrl.pc_write_ne;
  assign IorD          = ctrl.ior_d;
  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign RegDst        = ctrl.reg_dst;
  assign RegWrite      = ctrl.reg_write;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign ALUOp         = ctrl.alu_op;
  assign PCSource      = ctrl.pc_source;
  assign state_out     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed and random checks against an instruction-level reference model
module tb_multicycle_control_fsm;
  import mips_mc_pkg::*;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       reset, run, Zero, mem_ready;
  logic [5:0] OP, Funct;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
  logic       RegWrite, ALUSrcA, illegal_op, mem_timeout;
  logic [2:0] ALUOp;
  logic [3:0] state_out;
  logic [19:0] ctrl_obs;

  int         n_checks = 0, n_fail = 0;
  logic [5:0] ir_op = 6'h00, ir_fn = 6'h00;
  logic [11:0] prog[$];
  state_t     mphase, stall_ph;
  state_t     plan[$];
  int         m_cnt, stall_n, burst;
  logic       m_ill, m_to, rnd, obs_irw;
  logic [5:0] ops [12] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};

  multicycle_control_fsm #(.FETCH_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .run(run), .OP(OP), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state_out(state_out), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // control table: which strobes each step of an instruction raises
  function automatic logic [19:0] exp_ctrl(input state_t s, input logic [5:0] op, input logic go);
    logic pw, eq, ne, iord, mr, mw, irw, rw, asa;
    logic [1:0] m2r, rd, asb, pcs;
    logic [2:0] aop;
    {pw, eq, ne, iord, mr, mw, irw, rw, asa} = '0;
    {m2r, rd, asb, pcs} = '0;
    aop = 3'd0;
    case (s)
      S_FETCH:   begin mr = 1; asb = 1; aop = ALU_ADD; irw = go; pw = go; end
      S_DECODE:  begin asb = 3; aop = ALU_ADD; end
      S_MEMADDR: begin asa = 1; asb = 2; aop = ALU_ADD; end
      S_MEMRD:   begin iord = 1; mr = 1; end
      S_MEMWR:   begin iord = 1; mw = 1; end
      S_WB_MEM:  begin m2r = 1; rw = 1; end
      S_EXEC_R:  begin asa = 1; aop = ALU_RTYPE; end
      S_WB_R:    begin rd = 1; rw = 1; end
      S_EXEC_I:  begin
        asa = 1; asb = 2;
        aop = op == OP_ORI ? ALU_OR : op == OP_ANDI ? ALU_AND : op == OP_SLTI ? ALU_SLT :
              op == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      S_WB_I:    rw = 1;
      S_BRANCH:  begin asa = 1; aop = ALU_SUB; pcs = 1; eq = op == OP_BEQ; ne = op == OP_BNE; end
      S_JUMP:    begin pcs = 2; pw = 1; end
      S_JAL:     begin pcs = 2; pw = 1; rd = 2; m2r = 2; rw = 1; end
      S_JR:      begin pcs = 3; pw = 1; end
      default: ;
    endcase
    return {pw, eq, ne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  // latch the next instruction word and list the steps it must walk through
  task automatic fetch_instr();
    logic [11:0] w;
    int k;
    if (prog.size() != 0) w = prog.pop_front();
    else if (!rnd) w = {OP_ADDI, 6'h00};
    else begin
      k = $urandom_range(0, 13);
      w[11:6] = k < 12 ? ops[k] : k == 12 ? 6'h3F : 6'($urandom);
      w[5:0]  = $urandom_range(0, 1) != 0 ? FUNCT_JR : 6'($urandom);
    end
    {ir_op, ir_fn} = w;
    plan.delete();
    plan.push_back(S_DECODE);
    case (ir_op)
      OP_LW:   begin plan.push_back(S_MEMADDR); plan.push_back(S_MEMRD); plan.push_back(S_WB_MEM); end
      OP_SW:   begin plan.push_back(S_MEMADDR); plan.push_back(S_MEMWR); end
      OP_R:    if (ir_fn == FUNCT_JR) plan.push_back(S_JR);
               else begin plan.push_back(S_EXEC_R); plan.push_back(S_WB_R); end
      OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LUI: begin plan.push_back(S_EXEC_I); plan.push_back(S_WB_I); end
      OP_BEQ, OP_BNE: plan.push_back(S_BRANCH);
      OP_J:    plan.push_back(S_JUMP);
      OP_JAL:  plan.push_back(S_JAL);
      default: ;
    endcase
  endtask

  task automatic model_step();
    if (mphase == S_IDLE) begin
      if (run) mphase = S_FETCH;
    end else if (mphase == S_FETCH && m_cnt == 0 && !run) begin
      mphase = S_IDLE;
    end else if ((mphase == S_FETCH || mphase == S_MEMRD || mphase == S_MEMWR) && !mem_ready) begin
      if (m_cnt == MAXW - 1) begin
        m_to = 1'b1; m_cnt = 0; plan.delete(); mphase = S_FETCH;
      end else m_cnt++;
    end else begin
      if (mphase == S_FETCH) fetch_instr();
      else if (mphase == S_DECODE && plan.size() == 0) m_ill = 1'b1;
      m_cnt = 0;
      mphase = plan.size() != 0 ? plan.pop_front() : S_FETCH;
    end
  endtask

  task automatic cycle();
    logic go;
    @(negedge clk);
    if (rnd) begin
      if (burst == 0 && $urandom_range(0, 80) == 0) burst = $urandom_range(12, 17);
      mem_ready = burst > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (burst > 0) burst--;
      run = $urandom_range(0, 7) != 0;
    end else begin
      mem_ready = !(stall_n > 0 && mphase == stall_ph);
      if (!mem_ready) stall_n--;
      run = 1'b1;
    end
    Zero = rnd ? 1'($urandom) : 1'b1;
    OP = ir_op;
    Funct = ir_fn;
    go = mem_ready && (mphase != S_FETCH || m_cnt != 0 || run);
    #1;
    obs_irw = IRWrite;
    check("ctrl", ctrl_obs, exp_ctrl(mphase, ir_op, go));
    check("state", state_out, mphase);
    check("flags", {illegal_op, mem_timeout}, {m_ill, m_to});
    check("strobe_excl", {MemRead & MemWrite, RegWrite & MemWrite}, 0);
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ctrl", ctrl_obs, 0);
    check("rst_flags", {illegal_op, mem_timeout}, 0);
    check("rst_state", state_out, S_FETCH);
    mphase = S_FETCH; plan.delete(); prog.delete();
    m_cnt = 0; m_ill = 1'b0; m_to = 1'b0; burst = 0; stall_n = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("post_rst", {state_out, MemRead, IorD}, {4'(S_FETCH), 2'b10});
  endtask

  // cycles from the fetch that loads the instruction to the next fetch
  task automatic measure(input logic [5:0] op, input logic [5:0] fn, output int lat);
    int guard;
    prog.push_back({op, fn});
    guard = 0;
    do begin cycle(); guard++; end while (!obs_irw && guard < 40);
    lat = 0;
    do begin cycle(); lat++; end while (!obs_irw && lat < 40);
  endtask

  initial begin
    int lat, guard;
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0; OP = '0; Funct = '0; Zero = 1'b0;
    rnd = 1'b0; mphase = S_FETCH; stall_ph = S_FETCH; obs_irw = 1'b0;
    m_cnt = 0; stall_n = 0; burst = 0; m_ill = 1'b0; m_to = 1'b0;
    do_reset();

    prog.push_back({OP_R, 6'h20});
    guard = 0;
    do begin cycle(); guard++; end while (mphase != S_WB_R && guard < 40);
    #1 check("pre_rst_wbr", state_out, S_WB_R);
    do_reset();

    measure(OP_R, 6'h20, lat);    check("lat_add", lat, 4);
    measure(OP_ORI, 6'h00, lat);  check("lat_ori", lat, 4);
    measure(OP_SW, 6'h00, lat);   check("lat_sw", lat, 4);
    measure(OP_LW, 6'h00, lat);   check("lat_lw", lat, 5);
    stall_ph = S_MEMRD; stall_n = 3;
    measure(OP_LW, 6'h00, lat);   check("lat_lw_stall", lat, 8);
    measure(OP_BEQ, 6'h00, lat);  check("lat_beq", lat, 3);
    measure(OP_BNE, 6'h00, lat);  check("lat_bne", lat, 3);
    measure(OP_J, 6'h00, lat);    check("lat_j", lat, 3);
    measure(OP_JAL, 6'h00, lat);  check("lat_jal", lat, 3);
    measure(OP_R, FUNCT_JR, lat); check("lat_jr", lat, 3);
    #1 check("no_illegal_yet", illegal_op, 0);
    measure(6'h3F, 6'h00, lat);   check("lat_illegal", lat, 2);
    #1 check("illegal_set", illegal_op, 1);
    stall_ph = S_FETCH; stall_n = MAXW - 1;
    measure(OP_ADDI, 6'h00, lat); check("lat_fetch_wait14", lat, 4);
    #1 check("no_timeout_14", mem_timeout, 0);
    stall_n = MAXW;
    measure(OP_ADDI, 6'h00, lat); check("lat_after_timeout", lat, 4);
    #1 check("timeout_15", mem_timeout, 1);
    check("illegal_sticky", illegal_op, 1);

    rnd = 1'b1;
    repeat (4) begin
      do_reset();
      repeat (500) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
